// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding and reset coefficients for the TDM FIR scheduler.
package fir_pkg;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int PROD_W    = 32;
    localparam int ACC_W     = 34;
    localparam int FRAC_BITS = 15;

    localparam logic [COEF_W-1:0] B0_DEFAULT = 16'h1000;
    localparam logic [COEF_W-1:0] B1_DEFAULT = 16'h0800;
    localparam logic [COEF_W-1:0] B2_DEFAULT = 16'h0400;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAC0 = 3'd1,
        ST_MAC1 = 3'd2,
        ST_MAC2 = 3'd3,
        ST_OUT  = 3'd4
    } fir_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
// Zero latency; grants nothing while en is low.
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [$clog2(NUM_CH)-1:0] last_grant,
    input  logic                      en,
    output logic [NUM_CH-1:0]         gnt,
    output logic [$clog2(NUM_CH)-1:0] gnt_idx
);

    localparam int CH_W = $clog2(NUM_CH);

    always_comb begin
        logic            found;
        logic [CH_W-1:0] cand;
        int              sum;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        sum     = 0;
        // Search wraps so the last winner is considered last.
        for (int i = 1; i <= NUM_CH; i++) begin
            sum = int'(last_grant) + i;
            if (sum >= NUM_CH) begin
                sum = sum - NUM_CH;
            end
            cand = CH_W'(sum);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Round-robin TDM scheduler sharing one 3-tap Q1.15 FIR MAC across NUM_CH channels; 5 cycles/sample.
// Result held on OUT_* until OUT_READY, no grants or coefficient writes meanwhile; FIR_SAT_EN selects saturation.
module fir_tdm_scheduler
    import fir_pkg::*;
#(
    parameter int                NUM_CH  = 4,
    parameter logic [COEF_W-1:0] B0_INIT = B0_DEFAULT,
    parameter logic [COEF_W-1:0] B1_INIT = B1_DEFAULT,
    parameter logic [COEF_W-1:0] B2_INIT = B2_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       RESET_N,
    input  logic [NUM_CH-1:0]          IN_VALID,
    input  logic [NUM_CH*DATA_W-1:0]   IN_DATA,
    output logic [NUM_CH-1:0]          IN_READY,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [DATA_W-1:0]          OUT_DATA,
    output logic [$clog2(NUM_CH)-1:0]  OUT_CH,
    input  logic                       COEF_WE,
    input  logic [1:0]                 COEF_ADDR,
    input  logic [COEF_W-1:0]          COEF_WDATA,
    output logic                       COEF_READY
);

    localparam int CH_W = $clog2(NUM_CH);

    fir_sched_state_t state_q, state_d;

    logic [NUM_CH-1:0]        arb_gnt;
    logic [CH_W-1:0]          arb_idx;
    logic [CH_W-1:0]          last_grant_q;
    logic [CH_W-1:0]          ch_q;
    logic signed [DATA_W-1:0] in_samp [NUM_CH];
    logic signed [DATA_W-1:0] x1_q    [NUM_CH];
    logic signed [DATA_W-1:0] x2_q    [NUM_CH];
    logic signed [DATA_W-1:0] samp_q;
    logic signed [COEF_W-1:0] b0_q, b1_q, b2_q;
    logic signed [COEF_W-1:0] mul_a;
    logic signed [DATA_W-1:0] mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  res;
    logic [DATA_W-1:0]        res_dat;
    logic [DATA_W-1:0]        out_dat_q;
    logic                     in_xfer;
    logic                     coef_wr;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
        assign in_samp[c] = IN_DATA[DATA_W*c +: DATA_W];
    end

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req        (IN_VALID),
        .last_grant (last_grant_q),
        .en         (state_q == ST_IDLE),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx)
    );

    assign in_xfer = |(IN_VALID & arb_gnt);
    assign coef_wr = COEF_WE && (state_q == ST_IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_xfer) state_d = ST_MAC0;
            ST_MAC0: state_d = ST_MAC1;
            ST_MAC1: state_d = ST_MAC2;
            ST_MAC2: state_d = ST_OUT;
            ST_OUT:  if (OUT_READY) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        IN_READY   = arb_gnt;
        OUT_VALID  = (state_q == ST_OUT);
        COEF_READY = (state_q == ST_IDLE);
    end

    assign OUT_DATA = out_dat_q;
    assign OUT_CH   = ch_q;

    // One multiplier, operands steered by the tap being accumulated.
    always_comb begin
        mul_a = b0_q;
        mul_b = samp_q;
        case (state_q)
            ST_MAC1: begin
                mul_a = b1_q;
                mul_b = x1_q[ch_q];
            end
            ST_MAC2: begin
                mul_a = b2_q;
                mul_b = x2_q[ch_q];
            end
            default: ;
        endcase
    end

    assign prod     = PROD_W'(mul_a) * PROD_W'(mul_b);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_d    = (state_q == ST_MAC0) ? prod_ext : (acc_q + prod_ext);
    assign res      = acc_d >>> FRAC_BITS;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] RES_MIN = -ACC_W'(32768);

    always_comb begin
        res_dat = res[DATA_W-1:0];
        if (res > RES_MAX) begin
            res_dat = 16'h7FFF;
        end else if (res < RES_MIN) begin
            res_dat = 16'h8000;
        end
    end
`else
    logic unused_res_hi;

    assign res_dat       = res[DATA_W-1:0];
    assign unused_res_hi = ^res[ACC_W-1:DATA_W];
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            samp_q       <= '0;
            ch_q         <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
            acc_q        <= '0;
            out_dat_q    <= '0;
            b0_q         <= B0_INIT;
            b1_q         <= B1_INIT;
            b2_q         <= B2_INIT;
            for (int c = 0; c < NUM_CH; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
            end
        end else begin
            if (in_xfer) begin
                samp_q <= in_samp[arb_idx];
                ch_q   <= arb_idx;
            end
            if (coef_wr) begin
                case (COEF_ADDR)
                    2'd0:    b0_q <= COEF_WDATA;
                    2'd1:    b1_q <= COEF_WDATA;
                    2'd2:    b2_q <= COEF_WDATA;
                    default: ;
                endcase
            end
            if (state_q == ST_MAC0 || state_q == ST_MAC1 || state_q == ST_MAC2) begin
                acc_q <= acc_d;
            end
            // History only advances once the sample has been fully consumed.
            if (state_q == ST_MAC2) begin
                x2_q[ch_q] <= x1_q[ch_q];
                x1_q[ch_q] <= samp_q;
                out_dat_q  <= res_dat;
            end
            if (state_q == ST_OUT && OUT_READY) begin
                last_grant_q <= ch_q;
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Scoreboard bench for fir_tdm_scheduler: per-channel sources, reference FIR model, output log.
module tb_fir_tdm_scheduler;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    logic                 CLK = 1'b0;
    logic                 RESET_N = 1'b1;
    logic [NUM_CH-1:0]    IN_VALID;
    logic [NUM_CH*16-1:0] IN_DATA;
    logic [NUM_CH-1:0]    IN_READY;
    logic                 OUT_VALID;
    logic                 OUT_READY;
    logic [15:0]          OUT_DATA;
    logic [CH_W-1:0]      OUT_CH;
    logic                 COEF_WE;
    logic [1:0]           COEF_ADDR;
    logic [15:0]          COEF_WDATA;
    logic                 COEF_READY;

    fir_tdm_scheduler #(
        .NUM_CH  (NUM_CH),
        .B0_INIT (16'h1000),
        .B1_INIT (16'h0800),
        .B2_INIT (16'h0400)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .IN_VALID   (IN_VALID),
        .IN_DATA    (IN_DATA),
        .IN_READY   (IN_READY),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_CH     (OUT_CH),
        .COEF_WE    (COEF_WE),
        .COEF_ADDR  (COEF_ADDR),
        .COEF_WDATA (COEF_WDATA),
        .COEF_READY (COEF_READY)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    logic [15:0] src_q [NUM_CH][$];
    logic [31:0] sb[$];
    logic [31:0] out_log[$];
    int          mb [3];
    int          mx1 [NUM_CH];
    int          mx2 [NUM_CH];
    int          cyc = 0;
    int          xfer_edge = 0;
    int          n_xfer = 0;
    logic        prev_vld = 1'b0;
    logic        fair_chk = 1'b0;
    int          fair_exp = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model_out(input int c, input int x);
        longint acc;
        longint r;
        acc = longint'(mb[0]) * x + longint'(mb[1]) * mx1[c] + longint'(mb[2]) * mx2[c];
        r = acc >>> 15;
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    task automatic model_reset();
        mb[0] = 32'sh1000;
        mb[1] = 32'sh0800;
        mb[2] = 32'sh0400;
        for (int c = 0; c < NUM_CH; c++) begin
            mx1[c] = 0;
            mx2[c] = 0;
            src_q[c].delete();
        end
        sb.delete();
    endtask

    task automatic drive();
        for (int c = 0; c < NUM_CH; c++) begin
            IN_VALID[c] = (src_q[c].size() > 0);
            IN_DATA[c*16 +: 16] = (src_q[c].size() > 0) ? src_q[c][0] : 16'h0000;
        end
    endtask

    // Called mid-cycle: records the handshakes the coming rising edge will complete.
    task automatic observe();
        logic [15:0] x;
        logic [31:0] e;
        if (COEF_WE && COEF_READY && COEF_ADDR != 2'd3) mb[COEF_ADDR] = int'($signed(COEF_WDATA));
        if (fair_chk && IN_READY != '0) check_eq("one_hot_grant", $countones(IN_READY), 1);
        for (int c = 0; c < NUM_CH; c++) begin
            if (IN_VALID[c] && IN_READY[c]) begin
                x = src_q[c].pop_front();
                sb.push_back({16'(c), model_out(c, int'($signed(x)))});
                mx2[c] = mx1[c];
                mx1[c] = int'($signed(x));
                xfer_edge = cyc + 1;
                n_xfer++;
                if (fair_chk) begin
                    check_eq("grant_order", c, fair_exp);
                    fair_exp = (fair_exp + 1) % NUM_CH;
                end
            end
        end
        if (OUT_VALID && !prev_vld) check_eq("latency_edges", cyc + 1 - xfer_edge, 4);
        prev_vld = OUT_VALID;
        if (OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                check_eq("sb_depth", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check_eq("out_ch", OUT_CH, e[31:16]);
                check_eq("out_data", OUT_DATA, e[15:0]);
            end
            out_log.push_back({16'(OUT_CH), OUT_DATA});
        end
    endtask

    task automatic step();
        @(negedge CLK);
        observe();
        @(posedge CLK);
        cyc++;
        #1;
        drive();
    endtask

    function automatic int pending();
        int n;
        n = sb.size();
        for (int c = 0; c < NUM_CH; c++) n += src_q[c].size();
        return n;
    endfunction

    task automatic drain(input int budget);
        int n;
        n = 0;
        drive();
        while ((pending() != 0 || OUT_VALID || !COEF_READY) && n < budget) begin
            step();
            n++;
        end
        check_eq("drain_done", (n < budget), 1);
    endtask

    task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
        if (idx < out_log.size()) check_eq(tag, out_log[idx], exp);
        else check_eq(tag, out_log.size(), idx + 1);
    endtask

    task automatic coef_write(input logic [1:0] a, input logic [15:0] d);
        COEF_WE    = 1'b1;
        COEF_ADDR  = a;
        COEF_WDATA = d;
        step();
        COEF_WE    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] imp [3];
        logic [15:0] sat_exp [3];
        logic [31:0] e;
        int          k1, k2, n, base;

        imp[0] = 16'h0200;
        imp[1] = 16'h0100;
        imp[2] = 16'h0080;
        sat_exp[0] = 16'h7FFE;
`ifdef FIR_SAT_EN
        sat_exp[1] = 16'h7FFF;
        sat_exp[2] = 16'h7FFF;
`else
        sat_exp[1] = 16'hFFFC;
        sat_exp[2] = 16'h7FFA;
`endif

        IN_VALID = '0; IN_DATA = '0; OUT_READY = 1'b1;
        COEF_WE = 1'b0; COEF_ADDR = '0; COEF_WDATA = '0;
        model_reset();
        #2 RESET_N = 1'b0;
        #10;
        check_eq("rst_in_ready", IN_READY, 0);
        check_eq("rst_out_valid", OUT_VALID, 0);
        check_eq("rst_out_data", OUT_DATA, 0);
        check_eq("rst_out_ch", OUT_CH, 0);
        check_eq("rst_coef_ready", COEF_READY, 1);
        @(posedge CLK);
        #1 RESET_N = 1'b1;

        // Impulse on channel 0 with reset coefficients.
        out_log.delete();
        src_q[0].push_back(16'h1000); src_q[0].push_back(16'h0000); src_q[0].push_back(16'h0000);
        drain(200);
        for (int i = 0; i < 3; i++) check_log("impulse_ch0", i, {16'd0, imp[i]});

        // Channel isolation: ch1 impulse interleaved with ch2 silence.
        out_log.delete();
        src_q[1].push_back(16'h1000); src_q[1].push_back(16'h0000); src_q[1].push_back(16'h0000);
        src_q[2].push_back(16'h0000); src_q[2].push_back(16'h0000); src_q[2].push_back(16'h0000);
        drain(300);
        k1 = 0; k2 = 0;
        foreach (out_log[i]) begin
            e = out_log[i];
            if (e[31:16] == 16'd2) begin
                check_eq("iso_ch2_zero", e[15:0], 0);
                k2++;
            end else if (e[31:16] == 16'd1 && k1 < 3) begin
                check_eq("iso_ch1", e[15:0], imp[k1]);
                k1++;
            end
        end
        check_eq("iso_ch1_count", k1, 3);
        check_eq("iso_ch2_count", k2, 3);

        // Fairness: park last_grant on ch3, then hold all four requests high.
        src_q[3].push_back(16'($urandom));
        drain(100);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++) src_q[c].push_back(16'($urandom));
        fair_chk = 1'b1;
        fair_exp = 0;
        base = n_xfer;
        drain(400);
        fair_chk = 1'b0;
        check_eq("fair_xfers", n_xfer - base, 8);

        // Backpressure window with a dropped coefficient write.
        OUT_READY = 1'b0;
        src_q[3].push_back(16'h2345);
        src_q[0].push_back(16'h0123);
        drive();
        n = 0;
        while (!OUT_VALID && n < 50) begin
            step();
            n++;
        end
        check_eq("bp_valid", OUT_VALID, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                COEF_WE = 1'b1; COEF_ADDR = 2'd0; COEF_WDATA = 16'h1234;
            end else begin
                COEF_WE = 1'b0;
            end
            step();
            if (sb.size() == 0) begin
                check_eq("bp_sb", sb.size(), 1);
            end else begin
                e = sb[0];
                check_eq("bp_out_data", OUT_DATA, e[15:0]);
                check_eq("bp_out_ch", OUT_CH, e[31:16]);
            end
            check_eq("bp_out_valid", OUT_VALID, 1);
            check_eq("bp_in_ready", IN_READY, 0);
            check_eq("bp_coef_ready", COEF_READY, 0);
        end
        COEF_WE = 1'b0;
        OUT_READY = 1'b1;
        drain(200);

        // Reset during MAC1 after loading ch0 history.
        src_q[0].push_back(16'h2000);
        drain(100);
        src_q[0].push_back(16'h3000);
        drive();
        base = n_xfer;
        n = 0;
        while (n_xfer == base && n < 50) begin
            step();
            n++;
        end
        check_eq("rst_mac_xfer", n_xfer - base, 1);
        @(posedge CLK);
        cyc++;
        #1 RESET_N = 1'b0;
        #1;
        check_eq("rst_mac_out_valid", OUT_VALID, 0);
        check_eq("rst_mac_out_data", OUT_DATA, 0);
        check_eq("rst_mac_coef_ready", COEF_READY, 1);
        model_reset();
        prev_vld = 1'b0;
        @(posedge CLK);
        cyc++;
        #1 RESET_N = 1'b1;
        out_log.delete();
        src_q[0].push_back(16'h1000); src_q[0].push_back(16'h0000); src_q[0].push_back(16'h0000);
        drain(200);
        for (int i = 0; i < 3; i++) check_log("post_rst_impulse", i, {16'd0, imp[i]});

        // Saturation; b0 is written on the same edge as the first transfer.
        coef_write(2'd1, 16'h7FFF);
        coef_write(2'd2, 16'h7FFF);
        coef_write(2'd3, 16'h0000);
        out_log.delete();
        for (int i = 0; i < 3; i++) src_q[0].push_back(16'h7FFF);
        drive();
        COEF_WE = 1'b1; COEF_ADDR = 2'd0; COEF_WDATA = 16'h7FFF;
        step();
        COEF_WE = 1'b0;
        drain(200);
        for (int i = 0; i < 3; i++) check_log("saturation", i, {16'd0, sat_exp[i]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
